// File: rtl/vib_pkg.sv
// Shared types and constants for the FFT frame scheduler.
// The CHECKSUM_EN macro adds the trailing XOR byte state.
package vib_pkg;

    localparam logic [7:0]  HDR0          = 8'hA5;
    localparam logic [7:0]  HDR1          = 8'h5A;
    localparam int unsigned BYTES_PER_BIN = 3;
    localparam int unsigned SEL_W         = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SEND_HDR0,
        ST_SEND_HDR1,
        ST_SEND_BIN,
`ifdef CHECKSUM_EN
        ST_SEND_CSUM,
`endif
        ST_SEND_DONE
    } state_e;

    // Byte sel of a 24-bit magnitude, most significant byte first.
    function automatic logic [7:0] mag_byte(input logic [23:0] mag24, input logic [SEL_W-1:0] sel);
        case (sel)
            2'd0:    return mag24[23:16];
            2'd1:    return mag24[15:8];
            default: return mag24[7:0];
        endcase
    endfunction

endpackage

// File: rtl/mag_sq_stage.sv
// Registered magnitude-squared stage: mag = re*re + im*im on a packed
// {real, imag} word, with the input valid delayed alongside the result.
module mag_sq_stage #(
    parameter int unsigned HALF_W = 11,
    parameter int unsigned MAG_W  = 22
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_i,
    input  logic [2*HALF_W-1:0]   data_i,
    output logic                  valid_o,
    output logic [MAG_W-1:0]      mag_o
);

    localparam int unsigned PROD_W = 2 * HALF_W;
    localparam int unsigned SUM_W  = PROD_W + 1;

    logic signed [HALF_W-1:0] re_s;
    logic signed [HALF_W-1:0] im_s;
    logic signed [PROD_W-1:0] re_ext;
    logic signed [PROD_W-1:0] im_ext;
    logic signed [PROD_W-1:0] re_sq;
    logic signed [PROD_W-1:0] im_sq;
    logic        [SUM_W-1:0]  sum_c;
    logic                     valid_q;
    logic        [MAG_W-1:0]  mag_q;

    assign re_s   = data_i[2*HALF_W-1:HALF_W];
    assign im_s   = data_i[HALF_W-1:0];
    assign re_ext = PROD_W'(re_s);
    assign im_ext = PROD_W'(im_s);
    assign re_sq  = re_ext * re_ext;
    assign im_sq  = im_ext * im_ext;
    // Squares are non-negative, so zero-extension is exact.
    assign sum_c  = {1'b0, re_sq} + {1'b0, im_sq};

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            mag_q   <= '0;
        end else begin
            valid_q <= valid_i;
            mag_q   <= MAG_W'(sum_c);
        end
    end

    assign valid_o = valid_q;
    assign mag_o   = mag_q;

endmodule

// File: rtl/fft_frame_scheduler.sv
// Captures |X|^2 of bins 0..FFT_LEN/2-1 per FFT frame and streams them to a
// byte UART as A5 5A + 3 bytes/bin; CHECKSUM_EN appends an XOR of bin bytes.
module fft_frame_scheduler
    import vib_pkg::*;
#(
    parameter int unsigned FFT_LEN = 64,
    parameter int unsigned HALF_W  = 11,
    parameter int unsigned MAG_W   = 22
) (
    input  logic                  sys_clock,
    input  logic                  reset,
    input  logic                  fft_valid,
    input  logic                  fft_sync,
    input  logic [2*HALF_W-1:0]   fft_data,
    output logic [7:0]            tx_byte,
    output logic                  tx_start,
    input  logic                  tx_busy,
    output logic                  frame_active,
    output logic [7:0]            frames_sent,
    output logic [7:0]            frames_dropped
);

    localparam int unsigned HALF   = FFT_LEN / 2;
    localparam int unsigned ADDR_W = $clog2(HALF);
    localparam int unsigned IDX_W  = ADDR_W + 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]  bin_q, bin_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               wait_q, wait_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic               tx_start_q, tx_start_d;
    logic               active_q, active_d;
    logic [7:0]         sent_q, sent_d;
    logic [7:0]         dropped_q, dropped_d;
`ifdef CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    logic               accept_c;
    logic [ADDR_W-1:0]  acc_addr_c;
    logic               sync_c;
    logic               can_send_c;
    logic               send_req_c;
    logic [7:0]         send_byte_c;
    logic [7:0]         dropped_inc_c;

    logic               mag_vld;
    logic [MAG_W-1:0]   mag_val;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [MAG_W-1:0]   rd_data_q;
    logic [MAG_W-1:0]   mag_mem [HALF];

    mag_sq_stage #(
        .HALF_W (HALF_W),
        .MAG_W  (MAG_W)
    ) u_mag (
        .clk     (sys_clock),
        .reset   (reset),
        .valid_i (accept_c),
        .data_i  (fft_data),
        .valid_o (mag_vld),
        .mag_o   (mag_val)
    );

    // Simple dual-port buffer: pipelined write, registered read of the bin being sent.
    always_ff @(posedge sys_clock) begin
        if (accept_c) begin
            wr_addr_q <= acc_addr_c;
        end
        if (mag_vld) begin
            mag_mem[wr_addr_q] <= mag_val;
        end
        rd_data_q <= mag_mem[bin_q];
    end

    assign sync_c        = fft_valid && fft_sync;
    assign can_send_c    = !wait_q && !tx_busy;
    assign dropped_inc_c = (dropped_q == 8'hFF) ? dropped_q : dropped_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        bin_d       = bin_q;
        sel_d       = sel_q;
        wait_d      = wait_q;
        tx_byte_d   = tx_byte_q;
        tx_start_d  = 1'b0;
        sent_d      = sent_q;
        dropped_d   = dropped_q;
`ifdef CHECKSUM_EN
        csum_d      = csum_q;
`endif
        accept_c    = 1'b0;
        acc_addr_c  = '0;
        send_req_c  = 1'b0;
        send_byte_c = 8'h00;

        // Busy is not yet valid while tx_start is high; release wait afterwards.
        if (wait_q && !tx_start_q && !tx_busy) begin
            wait_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (sync_c) begin
                    accept_c = 1'b1;
                    idx_d    = IDX_W'(1);
                    state_d  = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (sync_c) begin
                    accept_c  = 1'b1;
                    idx_d     = IDX_W'(1);
                    dropped_d = dropped_inc_c;
                end else if (fft_valid && (idx_q < IDX_W'(HALF))) begin
                    accept_c   = 1'b1;
                    acc_addr_c = idx_q[ADDR_W-1:0];
                    idx_d      = idx_q + IDX_W'(1);
                end else if (mag_vld && (wr_addr_q == ADDR_W'(HALF - 1))) begin
                    state_d = ST_SEND_HDR0;
                    bin_d   = '0;
                    sel_d   = '0;
`ifdef CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                end
            end
            ST_SEND_HDR0: begin
                send_req_c  = 1'b1;
                send_byte_c = HDR0;
                if (can_send_c) state_d = ST_SEND_HDR1;
            end
            ST_SEND_HDR1: begin
                send_req_c  = 1'b1;
                send_byte_c = HDR1;
                if (can_send_c) state_d = ST_SEND_BIN;
            end
            ST_SEND_BIN: begin
                send_req_c  = 1'b1;
                send_byte_c = mag_byte(24'(rd_data_q), sel_q);
                if (can_send_c) begin
`ifdef CHECKSUM_EN
                    csum_d = csum_q ^ send_byte_c;
`endif
                    if (sel_q == SEL_W'(BYTES_PER_BIN - 1)) begin
                        sel_d = '0;
                        if (bin_q == ADDR_W'(HALF - 1)) begin
`ifdef CHECKSUM_EN
                            state_d = ST_SEND_CSUM;
`else
                            state_d = ST_SEND_DONE;
`endif
                        end else begin
                            bin_d = bin_q + ADDR_W'(1);
                        end
                    end else begin
                        sel_d = sel_q + SEL_W'(1);
                    end
                end
            end
`ifdef CHECKSUM_EN
            ST_SEND_CSUM: begin
                send_req_c  = 1'b1;
                send_byte_c = csum_q;
                if (can_send_c) state_d = ST_SEND_DONE;
            end
`endif
            ST_SEND_DONE: begin
                sent_d  = sent_q + 8'd1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A sync while sending loses that frame; nothing is queued.
        if (sync_c && (state_q != ST_IDLE) && (state_q != ST_CAPTURE)) begin
            dropped_d = dropped_inc_c;
        end

        if (send_req_c && can_send_c) begin
            tx_start_d = 1'b1;
            tx_byte_d  = send_byte_c;
            wait_d     = 1'b1;
        end

        active_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            bin_q      <= '0;
            sel_q      <= '0;
            wait_q     <= 1'b0;
            tx_byte_q  <= 8'h00;
            tx_start_q <= 1'b0;
            active_q   <= 1'b0;
            sent_q     <= 8'h00;
            dropped_q  <= 8'h00;
`ifdef CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            bin_q      <= bin_d;
            sel_q      <= sel_d;
            wait_q     <= wait_d;
            tx_byte_q  <= tx_byte_d;
            tx_start_q <= tx_start_d;
            active_q   <= active_d;
            sent_q     <= sent_d;
            dropped_q  <= dropped_d;
`ifdef CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign tx_byte        = tx_byte_q;
    assign tx_start       = tx_start_q;
    assign frame_active   = active_q;
    assign frames_sent    = sent_q;
    assign frames_dropped = dropped_q;

endmodule
